// File: rtl/divisor_parametrizado.sv
// Multi-channel programmable clock-enable divider: one tick and one square wave per channel.
// Define DIVISOR_CASCADE_EN to chain channel k onto the ticks of channel k-1.
module divisor_parametrizado #(
    parameter int          COUNT_WIDTH = 32,
    parameter int          NUM_CH      = 2,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sync,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] div_value,
    output logic [NUM_CH-1:0]             tick_out,
    output logic [NUM_CH-1:0]             square_out
);

    localparam logic [COUNT_WIDTH-1:0] DEF_DIV = COUNT_WIDTH'(DEFAULT_DIV);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [COUNT_WIDTH-1:0] div_act_q, div_act_d;
        logic [COUNT_WIDTH-1:0] div_pend_q, div_pend_d;
        logic                   pend_q, pend_d;
        logic                   tick_q, tick_d;
        logic                   square_q, square_d;
        logic [COUNT_WIDTH-1:0] div_in;
        logic                   adv;
        logic                   wrap;
        logic                   upd_sq;
        logic [COUNT_WIDTH:0]   half;

        assign div_in = div_value[k*COUNT_WIDTH +: COUNT_WIDTH];
        assign wrap   = (cnt_q == div_act_q - COUNT_WIDTH'(1));

`ifdef DIVISOR_CASCADE_EN
        if (k == 0) begin : g_adv_root
            assign adv = enable;
        end else begin : g_adv_chain
            assign adv = enable & tick_out[k-1];
        end
`else
        assign adv = enable;
`endif

        always_comb begin
            cnt_d      = cnt_q;
            div_act_d  = div_act_q;
            div_pend_d = div_pend_q;
            pend_d     = pend_q;
            tick_d     = tick_q;
            square_d   = square_q;
            upd_sq     = 1'b0;
            half       = '0;
            if (sync) begin
                cnt_d    = '0;
                tick_d   = 1'b0;
                square_d = 1'b0;
                pend_d   = 1'b0;
                if (load[k]) begin
                    div_act_d  = div_in;
                    div_pend_d = div_in;
                end else if (pend_q) begin
                    div_act_d = div_pend_q;
                end
            end else begin
                if (div_act_q == '0) begin
                    cnt_d    = '0;
                    tick_d   = 1'b0;
                    square_d = 1'b0;
                    if (pend_q) begin
                        div_act_d = div_pend_q;
                        pend_d    = 1'b0;
                    end
                end else if (adv) begin
                    upd_sq = 1'b1;
                    if (wrap) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        // New ratio only takes effect on a period boundary
                        if (pend_q) begin
                            div_act_d = div_pend_q;
                            pend_d    = 1'b0;
                        end
                    end else begin
                        cnt_d  = cnt_q + COUNT_WIDTH'(1);
                        tick_d = 1'b0;
                    end
                end else begin
                    tick_d = 1'b0;
                end
                if (load[k]) begin
                    div_pend_d = div_in;
                    pend_d     = 1'b1;
                end
            end
            // One extra bit so an all-ones divide value does not overflow
            half = ({1'b0, div_act_d} + (COUNT_WIDTH+1)'(1)) >> 1;
            if (upd_sq) begin
                square_d = ({1'b0, cnt_d} < half);
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_q      <= '0;
                div_act_q  <= DEF_DIV;
                div_pend_q <= '0;
                pend_q     <= 1'b0;
                tick_q     <= 1'b0;
                square_q   <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                div_pend_q <= div_pend_d;
                pend_q     <= pend_d;
                tick_q     <= tick_d;
                square_q   <= square_d;
            end
        end

        assign tick_out[k]   = tick_q;
        assign square_out[k] = square_q;
    end

endmodule

// File: tb/tb_divisor_parametrizado.sv
// Directed bench for divisor_parametrizado with DEFAULT_DIV overridden to 4.
module tb_divisor_parametrizado;

    localparam int CW = 16;
    localparam int NC = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           enable;
    logic           sync;
    logic [NC-1:0]  load;
    logic [NC*CW-1:0] div_value;
    logic [NC-1:0]  tick_out;
    logic [NC-1:0]  square_out;

    int checks = 0;
    int errors = 0;

    divisor_parametrizado #(
        .COUNT_WIDTH(CW),
        .NUM_CH     (NC),
        .DEFAULT_DIV(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .load      (load),
        .div_value (div_value),
        .tick_out  (tick_out),
        .square_out(square_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic et, es;
        reset = 1'b1; enable = 1'b1; sync = 1'b0;
        load = 2'b11; div_value = {16'd7, 16'd7};
        step();
        load = 2'b00;
        step();
        checks++;
        if (tick_out !== 2'b00) begin
            errors++; $display("FAIL reset_tick: got %b expected 00", tick_out);
        end
        checks++;
        if (square_out !== 2'b00) begin
            errors++; $display("FAIL reset_square: got %b expected 00", square_out);
        end
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            et = (e % 4 == 0);
            es = (e % 4 <= 1);
            checks++;
            if (tick_out[0] !== et) begin
                errors++; $display("FAIL default_tick0 edge %0d: got %b expected %b", e, tick_out[0], et);
            end
            checks++;
            if (square_out[0] !== es) begin
                errors++; $display("FAIL default_square0 edge %0d: got %b expected %b", e, square_out[0], es);
            end
`ifndef DIVISOR_CASCADE_EN
            checks++;
            if (tick_out[1] !== et || square_out[1] !== es) begin
                errors++; $display("FAIL default_ch1 edge %0d: got %b%b expected %b%b", e, tick_out[1], square_out[1], et, es);
            end
`endif
        end
    endtask

    task automatic test_div5_div1();
        logic et, es;
        sync = 1'b1; load = 2'b11; div_value = {16'd1, 16'd5};
        step();
        sync = 1'b0; load = 2'b00;
        checks++;
        if (tick_out !== 2'b00 || square_out !== 2'b00) begin
            errors++; $display("FAIL sync_clear: got %b/%b expected 00/00", tick_out, square_out);
        end
        for (int e = 1; e <= 15; e++) begin
            step();
            et = (e % 5 == 0);
            es = (e % 5 < 3);
            checks++;
            if (tick_out[0] !== et) begin
                errors++; $display("FAIL div5_tick edge %0d: got %b expected %b", e, tick_out[0], et);
            end
            checks++;
            if (square_out[0] !== es) begin
                errors++; $display("FAIL div5_square edge %0d: got %b expected %b", e, square_out[0], es);
            end
`ifndef DIVISOR_CASCADE_EN
            checks++;
            if (tick_out[1] !== 1'b1 || square_out[1] !== 1'b1) begin
                errors++; $display("FAIL div1 edge %0d: got %b%b expected 11", e, tick_out[1], square_out[1]);
            end
`endif
        end
    endtask

    task automatic test_midperiod_load();
        logic et, es;
        sync = 1'b1; load = 2'b01; div_value[15:0] = 16'd6;
        step();
        sync = 1'b0; load = 2'b00;
        for (int e = 1; e <= 29; e++) begin
            if (e == 3) begin
                load = 2'b01; div_value[15:0] = 16'd3;
            end else if (e == 18) begin
                load = 2'b01; div_value[15:0] = 16'd4;
            end else begin
                load = 2'b00;
            end
            step();
            et = (e == 6 || e == 9 || e == 12 || e == 15 || e == 18 ||
                  e == 21 || e == 25 || e == 29);
            if (e <= 2)       es = 1'b1;
            else if (e <= 5)  es = 1'b0;
            else if (e <= 20) es = ((e - 6) % 3 < 2);
            else              es = ((e - 21) % 4 < 2);
            checks++;
            if (tick_out[0] !== et) begin
                errors++; $display("FAIL midload_tick edge %0d: got %b expected %b", e, tick_out[0], et);
            end
            checks++;
            if (square_out[0] !== es) begin
                errors++; $display("FAIL midload_square edge %0d: got %b expected %b", e, square_out[0], es);
            end
        end
        load = 2'b00;
    endtask

    task automatic test_enable_freeze();
        logic et, es;
        sync = 1'b1; load = 2'b01; div_value[15:0] = 16'd8;
        step();
        sync = 1'b0; load = 2'b00;
        for (int e = 1; e <= 3; e++) step();
        enable = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (tick_out !== 2'b00) begin
                errors++; $display("FAIL freeze_tick cycle %0d: got %b expected 00", i, tick_out);
            end
            checks++;
            if (square_out[0] !== 1'b1) begin
                errors++; $display("FAIL freeze_square cycle %0d: got %b expected 1", i, square_out[0]);
            end
        end
        enable = 1'b1;
        for (int r = 1; r <= 24; r++) begin
            if (r == 6) begin
                load = 2'b01; div_value[15:0] = 16'd0;
            end else if (r == 18) begin
                load = 2'b01; div_value[15:0] = 16'd2;
            end else begin
                load = 2'b00;
            end
            step();
            et = (r == 5 || r == 13 || r == 21 || r == 23);
            checks++;
            if (tick_out[0] !== et) begin
                errors++; $display("FAIL resume_tick edge %0d: got %b expected %b", r, tick_out[0], et);
            end
            if (r <= 5 || r >= 13) begin
                es = (r == 5 || r == 21 || r == 23);
                checks++;
                if (square_out[0] !== es) begin
                    errors++; $display("FAIL resume_square edge %0d: got %b expected %b", r, square_out[0], es);
                end
            end
        end
        load = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic et, es;
        sync = 1'b1; load = 2'b01; div_value[15:0] = 16'd3;
        step();
        sync = 1'b0;
        div_value[15:0] = 16'd7;
        step();
        load = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (tick_out !== 2'b00 || square_out !== 2'b00) begin
            errors++; $display("FAIL midreset_clear: got %b/%b expected 00/00", tick_out, square_out);
        end
        for (int e = 1; e <= 8; e++) begin
            step();
            et = (e % 4 == 0);
            es = (e % 4 <= 1);
            checks++;
            if (tick_out[0] !== et || square_out[0] !== es) begin
                errors++; $display("FAIL midreset_run edge %0d: got %b%b expected %b%b", e, tick_out[0], square_out[0], et, es);
            end
        end
    endtask

    task automatic test_channels();
        logic et0, et1;
        sync = 1'b1; load = 2'b11; div_value = {16'd8, 16'd5};
        step();
        sync = 1'b0; load = 2'b00;
`ifdef DIVISOR_CASCADE_EN
        for (int e = 1; e <= 81; e++) begin
            step();
            et0 = (e % 5 == 0);
            et1 = (e == 41 || e == 81);
            checks++;
            if (tick_out[0] !== et0 || tick_out[1] !== et1) begin
                errors++; $display("FAIL cascade edge %0d: got %b expected %b%b", e, tick_out, et1, et0);
            end
        end
        for (int e = 1; e <= 3; e++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (tick_out !== 2'b00 || square_out !== 2'b00) begin
            errors++; $display("FAIL cascade_sync: got %b/%b expected 00/00", tick_out, square_out);
        end
        for (int e = 1; e <= 41; e++) begin
            step();
            et0 = (e % 5 == 0);
            et1 = (e == 41);
            checks++;
            if (tick_out[0] !== et0 || tick_out[1] !== et1) begin
                errors++; $display("FAIL cascade_realign edge %0d: got %b expected %b%b", e, tick_out, et1, et0);
            end
        end
`else
        for (int e = 1; e <= 40; e++) begin
            step();
            et0 = (e % 5 == 0);
            et1 = (e % 8 == 0);
            checks++;
            if (tick_out[0] !== et0 || tick_out[1] !== et1) begin
                errors++; $display("FAIL indep_tick edge %0d: got %b expected %b%b", e, tick_out, et1, et0);
            end
            checks++;
            if (square_out[1] !== (e % 8 < 4)) begin
                errors++; $display("FAIL indep_square1 edge %0d: got %b expected %b", e, square_out[1], (e % 8 < 4));
            end
        end
        for (int e = 1; e <= 3; e++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if (tick_out !== 2'b00 || square_out !== 2'b00) begin
            errors++; $display("FAIL indep_sync: got %b/%b expected 00/00", tick_out, square_out);
        end
        for (int e = 1; e <= 8; e++) begin
            step();
            et0 = (e % 5 == 0);
            et1 = (e == 8);
            checks++;
            if (tick_out[0] !== et0 || tick_out[1] !== et1) begin
                errors++; $display("FAIL indep_realign edge %0d: got %b expected %b%b", e, tick_out, et1, et0);
            end
        end
`endif
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sync = 1'b0; load = '0; div_value = '0;
        test_reset();
        test_div5_div1();
        test_midperiod_load();
        test_enable_freeze();
        test_reset_mid();
        test_channels();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
